// File: rtl/alu_mem_stage_pkg.sv
// Shared constants for the 24-bit execute/memory stage: ALUOp classes, ALU control codes, funct/opcode values.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package alu_mem_stage_pkg;

    localparam int WORD_W = 24;

    typedef logic [WORD_W-1:0] word_t;

    // ALUOp classes from the control unit
    localparam logic [1:0] ALUOP_MEM = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_I   = 2'b11;

    // ALU control word: bit3 = Bnegate, bits[2:0] = operation
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_NOR = 4'b0101;
    localparam logic [3:0] ALU_SLL = 4'b0110;
    localparam logic [3:0] ALU_SRL = 4'b0111;
    localparam logic [3:0] ALU_SUB = 4'b1010;
    localparam logic [3:0] ALU_SLT = 4'b1100;

    // R-type funct field
    localparam logic [3:0] FN_ADD = 4'b0000;
    localparam logic [3:0] FN_SUB = 4'b0001;
    localparam logic [3:0] FN_AND = 4'b0010;
    localparam logic [3:0] FN_OR  = 4'b0011;
    localparam logic [3:0] FN_XOR = 4'b0100;
    localparam logic [3:0] FN_NOR = 4'b0101;
    localparam logic [3:0] FN_SLT = 4'b0110;
    localparam logic [3:0] FN_SLL = 4'b0111;
    localparam logic [3:0] FN_SRL = 4'b1000;

    // I-type opcodes
    localparam logic [3:0] OP_ADDI = 4'b0100;
    localparam logic [3:0] OP_SUBI = 4'b0101;
    localparam logic [3:0] OP_SLTI = 4'b0110;
    localparam logic [3:0] OP_ANDI = 4'b0111;
    localparam logic [3:0] OP_ORI  = 4'b1000;

endpackage

// File: rtl/alu_mem_stage_alu_ctrl_decode.sv
// Decodes ALUOp/Opcode/Funct into the 4-bit ALU control word; unknown encodings fall back to ADD.
// Latency: combinational, zero cycles.
// Backpressure: none; no handshakes.
module alu_ctrl_decode
    import alu_mem_stage_pkg::*;
(
    input  logic [1:0] ALUOp,
    input  logic [3:0] Opcode,
    input  logic [3:0] Funct,
    output logic [3:0] ALUCtrl
);

    // Select the control word by class, then by funct (R-type) or opcode (I-type)
    always_comb begin
        ALUCtrl = ALU_ADD;
        case (ALUOp)
            ALUOP_MEM: ALUCtrl = ALU_ADD;
            ALUOP_BR:  ALUCtrl = ALU_SUB;
            ALUOP_R: begin
                case (Funct)
                    FN_ADD:  ALUCtrl = ALU_ADD;
                    FN_SUB:  ALUCtrl = ALU_SUB;
                    FN_AND:  ALUCtrl = ALU_AND;
                    FN_OR:   ALUCtrl = ALU_OR;
                    FN_XOR:  ALUCtrl = ALU_XOR;
                    FN_NOR:  ALUCtrl = ALU_NOR;
                    FN_SLT:  ALUCtrl = ALU_SLT;
                    FN_SLL:  ALUCtrl = ALU_SLL;
                    FN_SRL:  ALUCtrl = ALU_SRL;
                    default: ALUCtrl = ALU_ADD;
                endcase
            end
            ALUOP_I: begin
                case (Opcode)
                    OP_ADDI: ALUCtrl = ALU_ADD;
                    OP_SUBI: ALUCtrl = ALU_SUB;
                    OP_SLTI: ALUCtrl = ALU_SLT;
                    OP_ANDI: ALUCtrl = ALU_AND;
                    OP_ORI:  ALUCtrl = ALU_OR;
                    default: ALUCtrl = ALU_ADD;
                endcase
            end
            default: ALUCtrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/alu_mem_stage.sv
// 24-bit execute/memory stage: ALU with flags plus byte-addressed data memory of big-endian 3-byte words.
// Latency: ALU outputs and ReadData are combinational; stores land at the next rising Clock edge. ALU24_SHIFT_EN enables SLL/SRL.
// Backpressure: none; no handshakes, every cycle accepted.
module alu_mem_stage
    import alu_mem_stage_pkg::*;
#(
    parameter int DM_ADDR_W = 8
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic [1:0]          ALUOp,
    input  logic [3:0]          Opcode,
    input  logic [3:0]          Funct,
    input  logic [WORD_W-1:0]   A,
    input  logic [WORD_W-1:0]   B,
    input  logic [WORD_W-1:0]   WriteData,
    input  logic                MemWrite,
    input  logic                MemRead,
    output logic [3:0]          ALUCtrl,
    output logic [WORD_W-1:0]   Result,
    output logic                Zero,
    output logic                Overflow,
    output logic                CarryOut,
    output logic [WORD_W-1:0]   ReadData
);

    localparam int DM_DEPTH = 1 << DM_ADDR_W;
    localparam logic [DM_ADDR_W-1:0] ADDR_ONE = 1;

    logic          b_neg;
    word_t         b_eff;
    logic [WORD_W:0] sum;
    logic          add_ovf;

    logic [7:0]           mem [DM_DEPTH];
    logic [DM_ADDR_W-1:0] addr0;
    logic [DM_ADDR_W-1:0] addr1;
    logic [DM_ADDR_W-1:0] addr2;

    alu_ctrl_decode u_decode (
        .ALUOp   (ALUOp),
        .Opcode  (Opcode),
        .Funct   (Funct),
        .ALUCtrl (ALUCtrl)
    );

    // Shared adder: SUB and SLT both use it with B inverted and a carry-in of one
    always_comb begin
        b_neg   = ALUCtrl[3];
        b_eff   = b_neg ? ~B : B;
        sum     = {1'b0, A} + {1'b0, b_eff} + {{WORD_W{1'b0}}, b_neg};
        add_ovf = (A[WORD_W-1] == b_eff[WORD_W-1]) && (sum[WORD_W-1] != A[WORD_W-1]);
    end

    // Operation select; overflow and carry are only meaningful for ADD/SUB
    always_comb begin
        Result   = '0;
        Overflow = 1'b0;
        CarryOut = 1'b0;
        case (ALUCtrl)
            ALU_AND: Result = A & B;
            ALU_OR:  Result = A | B;
            ALU_XOR: Result = A ^ B;
            ALU_NOR: Result = ~(A | B);
            ALU_ADD, ALU_SUB: begin
                Result   = sum[WORD_W-1:0];
                Overflow = add_ovf;
                CarryOut = sum[WORD_W];
            end
            ALU_SLT: Result = {{(WORD_W-1){1'b0}}, sum[WORD_W-1] ^ add_ovf};
`ifdef ALU24_SHIFT_EN
            ALU_SLL: Result = (B[4:0] >= 5'd24) ? '0 : (A << B[4:0]);
            ALU_SRL: Result = (B[4:0] >= 5'd24) ? '0 : (A >> B[4:0]);
`else
            ALU_SLL: Result = '0;
            ALU_SRL: Result = '0;
`endif
            default: Result = '0;
        endcase
        Zero = (Result == '0);
    end

    // Word byte addresses; additions wrap modulo the memory size
    always_comb begin
        addr0    = Result[DM_ADDR_W-1:0];
        addr1    = addr0 + ADDR_ONE;
        addr2    = addr1 + ADDR_ONE;
        ReadData = MemRead ? {mem[addr0], mem[addr1], mem[addr2]} : '0;
    end

    // Memory update: reset clears every byte and wins over a same-cycle store
    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < DM_DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else if (MemWrite) begin
            mem[addr0] <= WriteData[23:16];
            mem[addr1] <= WriteData[15:8];
            mem[addr2] <= WriteData[7:0];
        end
    end

endmodule

// File: tb/tb_alu_mem_stage.sv
module tb_alu_mem_stage;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic [1:0]  ALUOp = 2'b00;
    logic [3:0]  Opcode = 4'h0;
    logic [3:0]  Funct = 4'h0;
    logic [23:0] A = '0;
    logic [23:0] B = '0;
    logic [23:0] WriteData = '0;
    logic        MemWrite = 1'b0;
    logic        MemRead = 1'b0;
    logic [3:0]  ALUCtrl;
    logic [23:0] Result;
    logic        Zero;
    logic        Overflow;
    logic        CarryOut;
    logic [23:0] ReadData;

    int checks = 0;
    int passes = 0;

`ifdef ALU24_SHIFT_EN
    localparam bit SHIFT_EN = 1'b1;
`else
    localparam bit SHIFT_EN = 1'b0;
`endif

    logic [7:0] mem_model [256];

    alu_mem_stage #(.DM_ADDR_W(8)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .ALUOp     (ALUOp),
        .Opcode    (Opcode),
        .Funct     (Funct),
        .A         (A),
        .B         (B),
        .WriteData (WriteData),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .ALUCtrl   (ALUCtrl),
        .Result    (Result),
        .Zero      (Zero),
        .Overflow  (Overflow),
        .CarryOut  (CarryOut),
        .ReadData  (ReadData)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Spec table: control word by class, funct or opcode
    function automatic logic [3:0] ref_ctrl(input logic [1:0] op, input logic [3:0] opc, input logic [3:0] fn);
        if (op == 2'b00) return 4'b0010;
        if (op == 2'b01) return 4'b1010;
        if (op == 2'b10) begin
            case (fn)
                4'd0: return 4'b0010;
                4'd1: return 4'b1010;
                4'd2: return 4'b0000;
                4'd3: return 4'b0001;
                4'd4: return 4'b0011;
                4'd5: return 4'b0101;
                4'd6: return 4'b1100;
                4'd7: return 4'b0110;
                4'd8: return 4'b0111;
                default: return 4'b0010;
            endcase
        end
        case (opc)
            4'd4: return 4'b0010;
            4'd5: return 4'b1010;
            4'd6: return 4'b1100;
            4'd7: return 4'b0000;
            4'd8: return 4'b0001;
            default: return 4'b0010;
        endcase
    endfunction

    function automatic longint sval(input logic [23:0] v);
        return v[23] ? longint'(v) - 64'sd16777216 : longint'(v);
    endfunction

    // Arithmetic reference: integer sums and signed ranges rather than bit-level adders
    task automatic ref_alu(input logic [3:0] ctrl, input logic [23:0] a, input logic [23:0] b,
                           output logic [23:0] res, output logic ovf, output logic cy);
        longint s;
        longint ss;
        int sh;
        res = 0; ovf = 0; cy = 0;
        sh = int'(b[4:0]);
        case (ctrl)
            4'b0000: res = a & b;
            4'b0001: res = a | b;
            4'b0011: res = a ^ b;
            4'b0101: res = ~(a | b);
            4'b0010: begin
                s = longint'(a) + longint'(b);
                ss = sval(a) + sval(b);
                res = s[23:0];
                cy = (s >= 64'sd16777216);
                ovf = (ss > 64'sd8388607) || (ss < -64'sd8388608);
            end
            4'b1010: begin
                s = longint'(a) + 64'sd16777216 - longint'(b);
                ss = sval(a) - sval(b);
                res = s[23:0];
                cy = (s >= 64'sd16777216);
                ovf = (ss > 64'sd8388607) || (ss < -64'sd8388608);
            end
            4'b1100: res = (sval(a) < sval(b)) ? 24'd1 : 24'd0;
            4'b0110: res = (SHIFT_EN && sh < 24) ? 24'((longint'(a) << sh) & 64'hFFFFFF) : 24'd0;
            4'b0111: res = (SHIFT_EN && sh < 24) ? 24'(longint'(a) >> sh) : 24'd0;
            default: res = 0;
        endcase
    endtask

    // One cycle: drive at negedge, check combinational outputs, then apply the upcoming edge to the model
    task automatic step(input string tag, input logic [1:0] op, input logic [3:0] opc, input logic [3:0] fn,
                        input logic [23:0] a, input logic [23:0] b, input logic [23:0] wd,
                        input logic mw, input logic mr, input logic rst);
        logic [3:0]  e_ctrl;
        logic [23:0] e_res;
        logic        e_ovf;
        logic        e_cy;
        logic [23:0] e_rd;
        int ad;
        @(negedge Clock);
        ALUOp = op; Opcode = opc; Funct = fn; A = a; B = b; WriteData = wd;
        MemWrite = mw; MemRead = mr; Reset = rst;
        #1;
        e_ctrl = ref_ctrl(op, opc, fn);
        ref_alu(e_ctrl, a, b, e_res, e_ovf, e_cy);
        ad = int'(e_res[7:0]);
        e_rd = mr ? {mem_model[ad], mem_model[(ad + 1) % 256], mem_model[(ad + 2) % 256]} : 24'h0;
        check({tag, ".ctrl"}, 32'(ALUCtrl), 32'(e_ctrl));
        check({tag, ".res"},  32'(Result),   32'(e_res));
        check({tag, ".zero"}, 32'(Zero),     32'(e_res == 24'h0));
        check({tag, ".ovf"},  32'(Overflow), 32'(e_ovf));
        check({tag, ".cy"},   32'(CarryOut), 32'(e_cy));
        check({tag, ".rd"},   32'(ReadData), 32'(e_rd));
        if (rst) begin
            for (int i = 0; i < 256; i++) mem_model[i] = 8'h00;
        end else if (mw) begin
            mem_model[ad]             = wd[23:16];
            mem_model[(ad + 1) % 256] = wd[15:8];
            mem_model[(ad + 2) % 256] = wd[7:0];
        end
    endtask

    initial begin
        // Reset and confirm reads return zero
        step("rst", 2'b00, 4'h0, 4'h0, 24'h0, 24'h0, 24'h0, 1'b0, 1'b0, 1'b1);
        step("rst_rd0", 2'b00, 4'h0, 4'h0, 24'h0, 24'h00, 24'h0, 1'b0, 1'b1, 1'b0);
        check("rst_rd0_const", 32'(ReadData), 32'h0);
        step("rst_rd1", 2'b00, 4'h0, 4'h0, 24'h0, 24'h7F, 24'h0, 1'b0, 1'b1, 1'b0);
        check("rst_rd1_const", 32'(ReadData), 32'h0);

        // Signed overflow on ADD
        step("add_ovf", 2'b10, 4'h0, 4'h0, 24'h7FFFFF, 24'h000001, 24'h0, 1'b0, 1'b0, 1'b0);
        check("tp_add_res", 32'(Result), 32'h800000);
        check("tp_add_ovf", 32'(Overflow), 32'h1);
        check("tp_add_cy", 32'(CarryOut), 32'h0);

        // Branch subtract of equal operands
        step("beq", 2'b01, 4'h0, 4'h0, 24'h123456, 24'h123456, 24'h0, 1'b0, 1'b0, 1'b0);
        check("tp_sub_ctrl", 32'(ALUCtrl), 32'hA);
        check("tp_sub_zero", 32'(Zero), 32'h1);
        check("tp_sub_cy", 32'(CarryOut), 32'h1);

        // Signed SLT both ways
        step("slt_a", 2'b10, 4'h0, 4'h6, 24'hFFFFFF, 24'h000001, 24'h0, 1'b0, 1'b0, 1'b0);
        check("tp_slt_a", 32'(Result), 32'h1);
        step("slt_b", 2'b10, 4'h0, 4'h6, 24'h000001, 24'hFFFFFF, 24'h0, 1'b0, 1'b0, 1'b0);
        check("tp_slt_b", 32'(Result), 32'h0);

        // Shifts, including out-of-range amounts
        step("sll5", 2'b10, 4'h0, 4'h7, 24'h000001, 24'h000005, 24'h0, 1'b0, 1'b0, 1'b0);
        check("tp_sll5", 32'(Result), SHIFT_EN ? 32'h20 : 32'h0);
        step("sll24", 2'b10, 4'h0, 4'h7, 24'h000001, 24'h000018, 24'h0, 1'b0, 1'b0, 1'b0);
        check("tp_sll24", 32'(Result), 32'h0);
        step("srl3", 2'b10, 4'h0, 4'h8, 24'h800000, 24'h000003, 24'h0, 1'b0, 1'b0, 1'b0);

        // Fallbacks for undefined funct and opcode, plus I-type decode
        step("fn_bad", 2'b10, 4'h0, 4'hF, 24'h000010, 24'h000020, 24'h0, 1'b0, 1'b0, 1'b0);
        step("op_bad", 2'b11, 4'h2, 4'h0, 24'h000010, 24'h000020, 24'h0, 1'b0, 1'b0, 1'b0);
        step("andi", 2'b11, 4'h7, 4'h0, 24'hF0F0F0, 24'h0FFF00, 24'h0, 1'b0, 1'b0, 1'b0);
        step("ori", 2'b11, 4'h8, 4'h0, 24'hF00000, 24'h00000F, 24'h0, 1'b0, 1'b0, 1'b0);
        step("nor", 2'b10, 4'h0, 4'h5, 24'hF00000, 24'h00000F, 24'h0, 1'b0, 1'b0, 1'b0);

        // Store with wrap at the top of memory, then read back
        step("st_wrap", 2'b00, 4'h0, 4'h0, 24'h0, 24'h0000FE, 24'hA1B2C3, 1'b1, 1'b0, 1'b0);
        step("ld_wrap", 2'b00, 4'h0, 4'h0, 24'h0, 24'h0000FE, 24'h0, 1'b0, 1'b1, 1'b0);
        check("tp_ld_wrap", 32'(ReadData), 32'hA1B2C3);
        step("ld_byte0", 2'b00, 4'h0, 4'h0, 24'h0, 24'h000000, 24'h0, 1'b0, 1'b1, 1'b0);
        check("tp_byte0", 32'(ReadData[23:16]), 32'hC3);
        step("ld_off", 2'b00, 4'h0, 4'h0, 24'h0, 24'h0000FE, 24'h0, 1'b0, 1'b0, 1'b0);
        check("tp_ld_off", 32'(ReadData), 32'h0);

        // Read and write together: read sees old contents
        step("rw", 2'b00, 4'h0, 4'h0, 24'h0, 24'h0000FE, 24'h112233, 1'b1, 1'b1, 1'b0);
        check("tp_rw_old", 32'(ReadData), 32'hA1B2C3);
        step("rw_after", 2'b00, 4'h0, 4'h0, 24'h0, 24'h0000FE, 24'h0, 1'b0, 1'b1, 1'b0);
        check("tp_rw_new", 32'(ReadData), 32'h112233);

        // Reset beats a simultaneous store
        step("st10", 2'b00, 4'h0, 4'h0, 24'h0, 24'h000010, 24'h5A5A5A, 1'b1, 1'b0, 1'b0);
        step("rst_wr", 2'b00, 4'h0, 4'h0, 24'h0, 24'h000010, 24'hDEADBE, 1'b1, 1'b0, 1'b1);
        step("rd10", 2'b00, 4'h0, 4'h0, 24'h0, 24'h000010, 24'h0, 1'b0, 1'b1, 1'b0);
        check("tp_rst_wr", 32'(ReadData), 32'h0);
        step("rdFE", 2'b00, 4'h0, 4'h0, 24'h0, 24'h0000FE, 24'h0, 1'b0, 1'b1, 1'b0);
        check("tp_rst_clr", 32'(ReadData), 32'h0);

        // Randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            logic [1:0]  r_op;
            logic [3:0]  r_opc;
            logic [3:0]  r_fn;
            logic [23:0] r_a;
            logic [23:0] r_b;
            r_op  = 2'($urandom_range(0, 3));
            r_opc = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(4, 8)) : 4'($urandom);
            r_fn  = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 8)) : 4'($urandom);
            r_a   = 24'($urandom);
            r_b   = ($urandom_range(0, 2) == 0) ? 24'($urandom_range(0, 31)) : 24'($urandom);
            if ($urandom_range(0, 5) == 0) r_b = r_a;
            step("rnd", r_op, r_opc, r_fn, r_a, r_b, 24'($urandom),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end

        @(negedge Clock);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/alu_mem_stage.md
# alu_mem_stage

24-bit execute/memory stage of the single-cycle CPU: decodes ALUOp/opcode/funct into a 4-bit ALU control word, performs the 24-bit ALU operation with flags, and hosts a byte-addressed data memory holding 3-byte words. Sits between the register file / ALUSrc mux (operands in) and the MemToReg mux and branch logic (result, flags, load data out). Decode and ALU are combinational; only the memory array is clocked.

## Interface
- DM_ADDR_W, default 8: data-memory byte-address width (2^DM_ADDR_W bytes).
- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high; clears the data memory.
- ALUOp  in  2  class from control unit: 00 load/store add, 01 branch subtract, 10 R-type by funct, 11 I-type by opcode.
- Opcode  in  4  instruction[23:20].
- Funct  in  4  instruction[3:0].
- A  in  24  operand A (readData1).
- B  in  24  operand B (after ALUSrc mux).
- WriteData  in  24  store data (readData2).
- MemWrite  in  1  store enable.
- MemRead  in  1  load enable.
- ALUCtrl  out  4  bit3 = Bnegate, bits[2:0] = operation.
- Result  out  24  ALU result; also the memory address.
- Zero  out  1  Result == 0.
- Overflow  out  1  signed overflow.
- CarryOut  out  1  carry out of bit 23.
- ReadData  out  24  load data.

## Operation
- ALUCtrl encodings: AND 0000, OR 0001, ADD 0010, XOR 0011, NOR 0101, SLL 0110, SRL 0111, SUB 1010, SLT 1100.
- ALUOp 00 → ADD; 01 → SUB.
- ALUOp 10, by Funct: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 NOR, 0110 SLT, 0111 SLL, 1000 SRL; any other value → ADD.
- ALUOp 11, by Opcode: 0100 ADDI→ADD, 0101 SUBI→SUB, 0110 SLTI→SLT, 0111 ANDI→AND, 1000 ORI→OR; any other value → ADD.
- ADD/SUB: A + (Bnegate ? ~B : B) + Bnegate, 25-bit sum.
  - CarryOut = sum bit 24. For SUB, 1 means no borrow.
  - Overflow = (A[23] == B'[23]) && (sum[23] != A[23]), where B' is the possibly inverted B.
- SLT: internal subtraction; Result = {23'b0, diff[23] ^ ovf}, signed compare.
- SLL/SRL: shift A by B[4:0], logical. Shift amounts 24–31 give 0.
- Flag rules:
  - Overflow and CarryOut are 0 for every operation except ADD and SUB.
  - Zero is computed for every operation.
- Memory address = Result[DM_ADDR_W-1:0].
- A word occupies bytes addr, addr+1, addr+2, big-endian (addr holds bits[23:16]). Byte indices wrap modulo 2^DM_ADDR_W.
- ReadData = assembled word when MemRead = 1, else 24'h000000.
- With MemRead and MemWrite both 1: ReadData shows pre-edge contents, and the write lands at the edge.

## Timing
- ALUCtrl, Result, Zero, Overflow, CarryOut and ReadData are combinational, with zero-cycle latency from their inputs.
- Write: on posedge Clock with MemWrite = 1, all three bytes are written in the same cycle.
- Reset: on posedge Clock with Reset = 1, every byte becomes 0x00.
  - Reset has priority over a simultaneous write; the write is dropped.
- After reset, ReadData = 0 for any address while MemRead = 1.
- No reset dependency on ALU outputs; they follow inputs at all times.
- No handshakes and no state machine.

## Configuration
- ALU24_SHIFT_EN defined: SLL and SRL are implemented as above.
- ALU24_SHIFT_EN undefined: ALUCtrl codes 0110/0111 still decode, but Result = 0 (Zero = 1, Overflow = CarryOut = 0). Shifter logic is absent.

## Structure
- Shared package holds:
  - ALUOp constants (ALUOP_MEM, ALUOP_BR, ALUOP_R, ALUOP_I);
  - ALUCtrl encodings;
  - Funct and I-type opcode constants;
  - word width 24.
- One natural sub-module: alu_ctrl_decode, the combinational ALUOp/Opcode/Funct → ALUCtrl decoder.
- ALU datapath and memory array stay in the top.

## Test plan
- ALUOp=10, Funct=0000, A=0x7FFFFF, B=0x000001 → Result 0x800000, Overflow 1, CarryOut 0, Zero 0.
- ALUOp=01, A=B=0x123456 → ALUCtrl 1010, Result 0, Zero 1, CarryOut 1, Overflow 0.
- ALUOp=10, Funct=0110: A=0xFFFFFF (−1), B=0x000001 → Result 1; swapping A and B → Result 0.
- ALUOp=10, SLL, A=0x000001, B=5 → 0x000020. With B=24 → 0. Without ALU24_SHIFT_EN → 0.
- Write A=B=0, store 0xA1B2C3 with addr 0xFE (B=0xFE, ALUOp=00) → bytes 0xFE=A1, 0xFF=B2, 0x00=C3. A following MemRead at 0xFE → 0xA1B2C3; MemRead=0 → 0.
- Reset together with MemWrite at addr 0x10 → all bytes 0, write discarded, and a read at 0x10 returns 0x000000.
